// File: rtl/riscv_upg_pkg.sv
// Shared definitions for the UART-programmer (UPG) image loader.
// Optional feature macro: UPG_CHECKSUM_EN (adds the trailing checksum byte and CSUM state).
package riscv_upg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_LEN0 = 3'd2,
        ST_LEN1 = 3'd3,
        ST_DATA = 3'd4,
`ifdef UPG_CHECKSUM_EN
        ST_CSUM = 3'd5,
`endif
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } upg_state_e;

    localparam logic [7:0] START_BYTE_DEF = 8'hA5;

    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

endpackage

// File: rtl/riscv_upg_word_asm.sv
// Byte-to-word assembler: shifts bytes in LSB first and flags the fourth byte of a word.
module riscv_upg_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_c,
    output logic        last_c
);

    logic [23:0] sr;
    logic [1:0]  byte_idx;

    // Only the three earlier bytes need storage; the fourth arrives with the strobe.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr       <= 24'd0;
            byte_idx <= 2'd0;
        end else if (shift_en) begin
            sr       <= {byte_in, sr[23:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word_c = {byte_in, sr};
    assign last_c = (byte_idx == 2'd3);

endmodule

// File: rtl/riscv_upg_loader.sv
// UPG writer: parses a framed byte stream and drives word writes into the target RAM.
// Optional feature macro: UPG_CHECKSUM_EN (XOR checksum byte after the data words).
module riscv_upg_loader
    import riscv_upg_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  START_BYTE  = START_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_sel_o,
    output logic              upg_done_o,
    output logic              upg_err_o,
    output logic              busy_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
`ifdef UPG_CHECKSUM_EN
    localparam upg_state_e ST_AFTER_DATA = ST_CSUM;
`else
    localparam upg_state_e ST_AFTER_DATA = ST_DONE;
`endif
    localparam logic AFTER_DATA_DONE = (ST_AFTER_DATA == ST_DONE);

    upg_state_e        state;
    logic [TO_W-1:0]   idle_cnt;
    logic [7:0]        len_lo;
    logic [15:0]       len_c;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] word_idx;
    logic              timeout_c;
    logic              shift_en_c;
    logic              asm_clr_c;
    logic [31:0]       word_c;
    logic              last_c;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign len_c      = {rx_data, len_lo};
    assign timeout_c  = (idle_cnt == TO_W'(TIMEOUT_CYC));
    assign shift_en_c = rx_valid && (state == ST_DATA) && !timeout_c;
    assign asm_clr_c  = (state != ST_DATA);

    riscv_upg_word_asm u_word_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr_c),
        .shift_en (shift_en_c),
        .byte_in  (rx_data),
        .word_c   (word_c),
        .last_c   (last_c)
    );

    // Frame parser FSM with registered RAM-port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idle_cnt   <= '0;
            len_lo     <= 8'd0;
            last_idx   <= '0;
            word_idx   <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= 32'd0;
            upg_sel_o  <= 1'b0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
            busy_o     <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            upg_wen_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    idle_cnt <= '0;
                    if (rx_valid && (rx_data == START_BYTE)) begin
                        state      <= ST_SEL;
                        busy_o     <= 1'b1;
                        upg_done_o <= 1'b0;
                        upg_err_o  <= 1'b0;
                        word_idx   <= '0;
`ifdef UPG_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                default: begin
                    if (timeout_c) begin
                        // A byte arriving in the timeout cycle is dropped.
                        state     <= ST_ERR;
                        upg_err_o <= 1'b1;
                        busy_o    <= 1'b0;
                        idle_cnt  <= '0;
                    end else if (!rx_valid) begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end else begin
                        idle_cnt <= '0;
`ifdef UPG_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        case (state)
                            ST_SEL: begin
                                if (rx_data[7:1] != 7'd0) begin
                                    state     <= ST_ERR;
                                    upg_err_o <= 1'b1;
                                    busy_o    <= 1'b0;
                                end else begin
                                    upg_sel_o <= rx_data[0] ? SEL_DATA : SEL_INST;
                                    state     <= ST_LEN0;
                                end
                            end
                            ST_LEN0: begin
                                len_lo <= rx_data;
                                state  <= ST_LEN1;
                            end
                            ST_LEN1: begin
                                if (len_c == 16'd0) begin
                                    state      <= ST_AFTER_DATA;
                                    upg_done_o <= AFTER_DATA_DONE;
                                    busy_o     <= !AFTER_DATA_DONE;
                                end else if ({16'd0, len_c} > (32'd1 << ADDR_W)) begin
                                    state     <= ST_ERR;
                                    upg_err_o <= 1'b1;
                                    busy_o    <= 1'b0;
                                end else begin
                                    last_idx <= ADDR_W'(len_c - 16'd1);
                                    state    <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (last_c) begin
                                    upg_wen_o <= 1'b1;
                                    upg_adr_o <= word_idx;
                                    upg_dat_o <= word_c;
                                    word_idx  <= word_idx + ADDR_W'(1);
                                    if (word_idx == last_idx) begin
                                        state      <= ST_AFTER_DATA;
                                        upg_done_o <= AFTER_DATA_DONE;
                                        busy_o     <= !AFTER_DATA_DONE;
                                    end
                                end
                            end
`ifdef UPG_CHECKSUM_EN
                            ST_CSUM: begin
                                busy_o <= 1'b0;
                                if (rx_data == csum) begin
                                    state      <= ST_DONE;
                                    upg_done_o <= 1'b1;
                                end else begin
                                    state     <= ST_ERR;
                                    upg_err_o <= 1'b1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
